// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding byte/half/word accesses against a
// word-addressed, synchronous-read data memory; sub-word stores use read-modify-write.
module load_store_unit #(
  parameter int WORD_ADDR_BITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPTURE = 3'd2,
    RMW_ISSUE  = 3'd3,
    RMW_MERGE  = 3'd4,
    WRITE      = 3'd5,
    RESP       = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [WORD_ADDR_BITS-1:0] widx_q;
  logic [1:0]                off_q;
  logic [1:0]                size_q;
  logic                      unsigned_q;
  logic [15:0]               lane_q;
  logic [31:0]               wword_q;
  logic [31:0]               rdata_q;
  logic                      err_q;

  logic        accept;
  logic        req_err;
  logic [31:0] load_val;
  logic [31:0] merge_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Handshake: a request transfers on a cycle where req_valid && req_ready.
  assign accept  = req_valid && req_ready;
  assign req_err = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || (|req_addr[31:WORD_ADDR_BITS+2]);

  assign req_ready      = !reset && (state_q == IDLE);
  assign mem_read       = !reset && (state_q == RD_ISSUE || state_q == RMW_ISSUE);
  assign mem_write      = !reset && (state_q == WRITE);
  assign resp_valid     = !reset && (state_q == RESP);
  assign resp_error     = resp_valid && err_q;
  assign resp_rdata     = rdata_q;
  assign mem_address    = {{(32-WORD_ADDR_BITS){1'b0}}, widx_q};
  assign mem_write_data = wword_q;
  assign dbg_state      = state_q;

  // Little-endian lane extraction and merge against the fetched word.
  always_comb begin
    byte_sel   = mem_read_data[{off_q, 3'b000} +: 8];
    half_sel   = mem_read_data[{off_q[1], 4'b0000} +: 16];
    load_val   = mem_read_data;
    merge_word = mem_read_data;
    case (size_q)
      2'b00: begin
        load_val = unsigned_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merge_word[{off_q, 3'b000} +: 8] = lane_q[7:0];
      end
      2'b01: begin
        load_val = unsigned_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merge_word[{off_q[1], 4'b0000} +: 16] = lane_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                state_d = RESP;
          else if (!req_write)        state_d = RD_ISSUE;
          else if (req_size == 2'b10) state_d = WRITE;
          else                        state_d = RMW_ISSUE;
        end
      end
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = RESP;
      RMW_ISSUE:  state_d = RMW_MERGE;
      RMW_MERGE:  state_d = WRITE;
      WRITE:      state_d = RESP;
      RESP:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      widx_q     <= '0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      lane_q     <= 16'h0;
      wword_q    <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            widx_q     <= req_addr[WORD_ADDR_BITS+1:2];
            off_q      <= req_addr[1:0];
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            lane_q     <= req_wdata[15:0];
            wword_q    <= req_wdata;
            err_q      <= req_err;
            // rdata only changes as a response is launched
            if (req_err) rdata_q <= 32'h0;
          end
        end
        RD_CAPTURE: rdata_q <= load_val;
        RMW_MERGE:  wword_q <= merge_word;
        WRITE:      rdata_q <= 32'h0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a synchronous-read memory model
// and a response scoreboard checked by an independent monitor.
module tb_load_store_unit;

  localparam int W = 37;  // {latency[3:0], error, rdata[31:0]}

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;
  logic [2:0]  dbg_state;

  load_store_unit #(.WORD_ADDR_BITS(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [31:0] mem [8];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[2:0]] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem[mem_address[2:0]];
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [31:0]  exp_wr_q[$];
  int n_vec = 0;
  int n_miss = 0;
  int cur_acc = 0, cur_rd_lat = 0, cur_wr_lat = 0, rd_cnt = 0, wr_cnt = 0;
  logic [31:0] cur_widx = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e, g;
    if (resp_valid) begin
      n_vec++;
      g = {4'(cyc - cur_acc), resp_error, resp_rdata};
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL resp_unexpected: got lat=%0d err=%0b rdata=0x%08h", g[36:33], g[32], g[31:0]);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          n_miss++;
          $display("FAIL resp: got lat=%0d err=%0b rdata=0x%08h expected lat=%0d err=%0b rdata=0x%08h",
                   g[36:33], g[32], g[31:0], e[36:33], e[32], e[31:0]);
        end
      end
    end
    if (mem_read) begin
      rd_cnt++;
      n_vec++;
      if (cur_rd_lat == 0 || cyc - cur_acc != cur_rd_lat || mem_address !== cur_widx || mem_write) begin
        n_miss++;
        $display("FAIL mem_read: got lat=%0d addr=%0d wr=%0b expected lat=%0d addr=%0d",
                 cyc - cur_acc, mem_address, mem_write, cur_rd_lat, cur_widx);
      end
    end
    if (mem_write) begin
      wr_cnt++;
      n_vec++;
      if (cur_wr_lat == 0 || exp_wr_q.size() == 0) begin
        n_miss++;
        $display("FAIL mem_write_unexpected: got lat=%0d addr=%0d data=0x%08h", cyc - cur_acc, mem_address, mem_write_data);
      end else begin
        logic [31:0] d;
        d = exp_wr_q.pop_front();
        if (cyc - cur_acc != cur_wr_lat || mem_address !== cur_widx || mem_write_data !== d) begin
          n_miss++;
          $display("FAIL mem_write: got lat=%0d addr=%0d data=0x%08h expected lat=%0d addr=%0d data=0x%08h",
                   cyc - cur_acc, mem_address, mem_write_data, cur_wr_lat, cur_widx, d);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready(input string name);
    int guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: req_ready got 0 expected 1", name);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    wait_ready("issue");
    req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    cur_acc = cyc; cur_widx = {29'h0, addr[4:2]};
    rd_cnt = 0; wr_cnt = 0;
  endtask

  task automatic do_req(input string name, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input logic err, input logic [31:0] rdata,
                        input int rd_lat, input int wr_lat, input logic [31:0] wr_data);
    logic [3:0] l4;
    issue(wr, sz, uns, addr, wdata);
    cur_rd_lat = rd_lat; cur_wr_lat = wr_lat;
    l4 = 4'(lat);
    exp_q.push_back({l4, err, rdata});
    if (wr_lat != 0) exp_wr_q.push_back(wr_data);
    @(negedge clk);
    req_valid = 1'b0;
    wait_ready(name);
    chk({name, "_reads"},  rd_cnt, (rd_lat != 0) ? 1 : 0);
    chk({name, "_writes"}, wr_cnt, (wr_lat != 0) ? 1 : 0);
  endtask

  initial begin
    #200000;
    n_miss++;
    $display("FAIL watchdog: run got stuck expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_ready", req_ready, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_mem_rw", {mem_read, mem_write}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", req_ready, 1);
    chk("post_reset_addr", mem_address, 0);
    chk("post_reset_wdata", mem_write_data, 0);
    chk("post_reset_rdata", resp_rdata, 0);
    chk("post_reset_error", resp_error, 0);
    chk("post_reset_state", dbg_state, 0);

    // preload through word stores
    do_req("st_w_10", 1, 2'b10, 0, 32'h10, 32'h0000_03FF, 2, 0, 0, 0, 1, 32'h0000_03FF);
    do_req("st_w_04", 1, 2'b10, 0, 32'h04, 32'h0000_001C, 2, 0, 0, 0, 1, 32'h0000_001C);
    // loads
    do_req("ld_b_s",  0, 2'b00, 0, 32'h10, 0, 3, 0, 32'hFFFF_FFFF, 1, 0, 0);
    do_req("ld_b_u",  0, 2'b00, 1, 32'h10, 0, 3, 0, 32'h0000_00FF, 1, 0, 0);
    do_req("ld_h_12", 0, 2'b01, 0, 32'h12, 0, 3, 0, 32'h0000_0000, 1, 0, 0);
    do_req("ld_w_04", 0, 2'b10, 1, 32'h04, 0, 3, 0, 32'h0000_001C, 1, 0, 0);
    // byte store by read-modify-write
    do_req("st_b_11", 1, 2'b00, 0, 32'h11, 32'h1234_56AB, 4, 0, 0, 1, 3, 32'h0000_ABFF);
    do_req("ld_w_10", 0, 2'b10, 0, 32'h10, 0, 3, 0, 32'h0000_ABFF, 1, 0, 0);
    do_req("ld_h_s",  0, 2'b01, 0, 32'h10, 0, 3, 0, 32'hFFFF_ABFF, 1, 0, 0);
    do_req("st_w_1c", 1, 2'b10, 0, 32'h1C, 32'hDEAD_BEEF, 2, 0, 0, 0, 1, 32'hDEAD_BEEF);
    do_req("ld_b_1f", 0, 2'b00, 1, 32'h1F, 0, 3, 0, 32'h0000_00DE, 1, 0, 0);
    do_req("ld_b_1e", 0, 2'b00, 0, 32'h1E, 0, 3, 0, 32'hFFFF_FFAD, 1, 0, 0);
    // error cases
    do_req("err_ld_w_06", 0, 2'b10, 0, 32'h06, 0, 1, 1, 0, 0, 0, 0);
    do_req("err_st_h_03", 1, 2'b01, 0, 32'h03, 32'hFFFF_FFFF, 1, 1, 0, 0, 0, 0);
    do_req("err_size",    0, 2'b11, 0, 32'h10, 0, 1, 1, 0, 0, 0, 0);
    do_req("err_range",   0, 2'b10, 0, 32'h20, 0, 1, 1, 0, 0, 0, 0);
    // half store in the upper lane
    do_req("st_h_1e", 1, 2'b01, 0, 32'h1E, 32'h5555_8001, 4, 0, 0, 1, 3, 32'h8001_BEEF);
    do_req("ld_h_1e", 0, 2'b01, 0, 32'h1E, 0, 3, 0, 32'hFFFF_8001, 1, 0, 0);
    chk("rdata_hold", resp_rdata, 32'hFFFF_8001);

    // reset during RMW_MERGE of a byte store abandons it
    issue(1, 2'b00, 0, 32'h11, 32'h0000_0077);
    cur_rd_lat = 1; cur_wr_lat = 0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_merge_state", dbg_state, 4);
    reset = 1'b1;
    #1;
    chk("mid_reset_ready", req_ready, 0);
    chk("mid_reset_mem_rw", {mem_read, mem_write}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset_ready", req_ready, 1);
    chk("after_reset_reads", rd_cnt, 1);
    chk("after_reset_writes", wr_cnt, 0);
    do_req("ld_w_10_b", 0, 2'b10, 0, 32'h10, 0, 3, 0, 32'h0000_ABFF, 1, 0, 0);

    repeat (3) @(negedge clk);
    chk("resp_queue_empty", exp_q.size(), 0);
    chk("write_queue_empty", exp_wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
